// File: rtl/ora_misr_gen_pkg.sv
// ---------------------------------------------------------------------------
// ora_pkg
//   Shared definitions for the output-response-analyser MISR block.
//   - ora_state_t  : session FSM state encoding (IDLE / COMPACT / DONE)
//   - POLY_W*      : default Galois feedback tap masks for common widths
//   - default_poly : picks the default tap mask for a given signature width
// ---------------------------------------------------------------------------
package ora_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPACT = 2'd1,
        ST_DONE    = 2'd2
    } ora_state_t;

    // Bit i set means the MSB is fed back into stage i; bit 0 is always set.
    localparam logic [3:0]  POLY_W4  = 4'b0011;
    localparam logic [7:0]  POLY_W8  = 8'h1D;
    localparam logic [15:0] POLY_W16 = 16'h002D;

    // Default tap mask for a width; widths without a named mask fall back to
    // the 4-bit mask, which still has stage 0 fed back.
    function automatic logic [31:0] default_poly(input int width);
        logic [31:0] poly;
        case (width)
            8:       poly = {24'd0, POLY_W8};
            16:      poly = {16'd0, POLY_W16};
            default: poly = {28'd0, POLY_W4};
        endcase
        return poly;
    endfunction

endpackage

// File: rtl/ora_misr_gen_misr_core.sv
// ---------------------------------------------------------------------------
// misr_core
//   Galois-form multiple-input signature register.
//   Ports:
//     clock    : rising-edge clock
//     reset    : asynchronous active-low reset, clears the signature
//     load     : load load_val into the signature (has priority over en)
//     en       : perform one compaction step with data_in
//     load_val : value loaded on load (session seed)
//     data_in  : parallel response bits folded into stages 0..IN_W-1
//     sig      : current signature
//     sig_next : signature the next enabled step would produce; lets the
//                controller compare against the golden value on the same
//                edge that commits the final step
// ---------------------------------------------------------------------------
module misr_core #(
    parameter int               WIDTH = 4,
    parameter int               IN_W  = 2,
    parameter logic [WIDTH-1:0] POLY  = 4'b0011
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] load_val,
    input  logic [IN_W-1:0]  data_in,
    output logic [WIDTH-1:0] sig,
    output logic [WIDTH-1:0] sig_next
);

    logic [WIDTH-1:0] sig_q;
    logic [WIDTH-1:0] sig_d;
    logic [WIDTH-1:0] step;

    // Shift towards the MSB, inject the MSB at every tapped stage, then fold
    // the response bits into the low stages.
    always_comb begin
        step = {sig_q[WIDTH-2:0], 1'b0} ^ (POLY & {WIDTH{sig_q[WIDTH-1]}});
        for (int i = 0; i < IN_W; i++) begin
            step[i] = step[i] ^ data_in[i];
        end
    end

    always_comb begin
        sig_d = sig_q;
        if (load) begin
            sig_d = load_val;
        end else if (en) begin
            sig_d = step;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig      = sig_q;
    assign sig_next = step;

endmodule

// File: rtl/ora_misr_gen.sv
// ---------------------------------------------------------------------------
// ora_misr_gen
//   Output-response analyser: compacts numPatterns qualified response words
//   into a MISR signature and compares the result with a golden signature.
//   Ports:
//     clock, reset : rising-edge clock, asynchronous active-low reset
//     start        : begin a session (from IDLE or DONE; ignored in COMPACT)
//     abort        : return to IDLE, clear done/pass, hold the signature
//     seed         : signature loaded on start
//     numPatterns  : responses per session, sampled on start
//     dataIn       : response bits, qualified by dataValid
//     golden       : expected signature, sampled on the final compaction edge
//     dataOut      : current signature
//     busy / done  : high in COMPACT / DONE
//     pass         : registered match result, meaningful while done=1
//     dbg_state    : current FSM state
//
//   Handshake: a response is consumed on every rising edge where the block is
//   in COMPACT and dataValid=1; there is no back-pressure, the block accepts
//   one response per cycle while busy=1.
// ---------------------------------------------------------------------------
module ora_misr_gen
    import ora_pkg::*;
#(
    parameter int               WIDTH = 4,
    parameter int               IN_W  = 2,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(default_poly(WIDTH)),
    parameter int               CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] seed,
    input  logic [CNT_W-1:0] numPatterns,
    input  logic [IN_W-1:0]  dataIn,
    input  logic             dataValid,
    input  logic [WIDTH-1:0] golden,
    output logic [WIDTH-1:0] dataOut,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [1:0]       dbg_state
);

    ora_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] target_q, target_d;
    logic             pass_q, pass_d;

    logic             misr_load;
    logic             misr_en;
    logic [WIDTH-1:0] sig;
    logic [WIDTH-1:0] sig_next;
    logic [CNT_W-1:0] cnt_inc;

    misr_core #(
        .WIDTH (WIDTH),
        .IN_W  (IN_W),
        .POLY  (POLY)
    ) u_misr (
        .clock    (clock),
        .reset    (reset),
        .load     (misr_load),
        .en       (misr_en),
        .load_val (seed),
        .data_in  (dataIn),
        .sig      (sig),
        .sig_next (sig_next)
    );

    // The session ends when the count reaches the target, so the increment
    // never wraps for any legal target.
    assign cnt_inc = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        target_d  = target_q;
        pass_d    = pass_q;
        misr_load = 1'b0;
        misr_en   = 1'b0;

        if (abort) begin
            // Abort beats start and leaves the signature untouched.
            state_d = ST_IDLE;
            pass_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        misr_load = 1'b1;
                        target_d  = numPatterns;
                        cnt_d     = '0;
                        if (numPatterns == '0) begin
                            // Empty session: the seed itself is the signature.
                            state_d = ST_DONE;
                            pass_d  = (seed == golden);
                        end else begin
                            state_d = ST_COMPACT;
                            pass_d  = 1'b0;
                        end
                    end
                end
                ST_COMPACT: begin
                    if (dataValid) begin
                        misr_en = 1'b1;
                        cnt_d   = cnt_inc;
                        if (cnt_inc == target_q) begin
                            state_d = ST_DONE;
                            pass_d  = (sig_next == golden);
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    pass_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            target_q <= '0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            target_q <= target_d;
            pass_q   <= pass_d;
        end
    end

    assign dataOut   = sig;
    assign busy      = (state_q == ST_COMPACT);
    assign done      = (state_q == ST_DONE);
    assign pass      = pass_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_ora_misr_gen.sv
// ---------------------------------------------------------------------------
// tb_ora_misr_gen
//   Bench for ora_misr_gen at WIDTH=4, IN_W=2, POLY=4'b0011.
//   The reference signature treats the register as a polynomial over GF(2):
//   each step multiplies by x, reduces modulo x^4 + POLY, and adds the
//   response word. Each session's final {signature, pass} is queued when the
//   session starts and checked when done rises.
// ---------------------------------------------------------------------------
module tb_ora_misr_gen;
    import ora_pkg::*;

    localparam int         W  = 4;
    localparam int         IW = 2;
    localparam int         CW = 8;
    localparam logic [W-1:0] P = 4'b0011;

    // ---------------- clock / reset ----------------
    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic          abort;
    logic [W-1:0]  seed;
    logic [CW-1:0] numPatterns;
    logic [IW-1:0] dataIn;
    logic          dataValid;
    logic [W-1:0]  golden;
    logic [W-1:0]  dataOut;
    logic          busy;
    logic          done;
    logic          pass;
    logic [1:0]    dbg_state;

    always #5 clock = ~clock;

    ora_misr_gen #(
        .WIDTH (W),
        .IN_W  (IW),
        .POLY  (P),
        .CNT_W (CW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .seed        (seed),
        .numPatterns (numPatterns),
        .dataIn      (dataIn),
        .dataValid   (dataValid),
        .golden      (golden),
        .dataOut     (dataOut),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .dbg_state   (dbg_state)
    );

    // ---------------- bookkeeping ----------------
    int total = 0;
    int bad   = 0;
    logic [W:0] exp_q[$];      // {signature, pass}
    logic [IW-1:0] resp_q[$];  // responses of the next session
    int gap_q[$];              // idle cycles after each response
    logic [W-1:0] model_sig;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: multiply by x modulo x^W + POLY, then add the response.
    function automatic logic [W-1:0] ref_step(input logic [W-1:0] s, input logic [IW-1:0] d);
        int unsigned v;
        v = 2 * int'(s);
        if (v >= (1 << W)) v = v ^ ((1 << W) | int'(P));
        v = v ^ int'(d);
        return v[W-1:0];
    endfunction

    // ---------------- monitor ----------------
    logic       done_prev = 1'b0;
    logic [W:0] mon_e;

    always @(negedge clock) begin
        if (reset && done && !done_prev) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 expected no pending session at %0t", $time);
            end else begin
                mon_e = exp_q.pop_front();
                check("sb_signature", 32'(dataOut), 32'(mon_e[W:1]));
                check("sb_pass", 32'(pass), 32'(mon_e[0]));
            end
        end
        done_prev <= done;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Runs the session held in resp_q/gap_q. abort_idx >= 0 asserts abort
    // together with start in place of that response.
    task automatic run_session(input logic [W-1:0] s, input logic [W-1:0] g, input int abort_idx);
        logic [W-1:0] fin;
        int n;
        n = resp_q.size();
        if (n == 0 && done) begin
            abort = 1'b1;
            tick();
            abort = 1'b0;
            check("pre_abort_done", 32'(done), 32'd0);
        end
        fin = s;
        foreach (resp_q[i]) fin = ref_step(fin, resp_q[i]);
        if (abort_idx < 0) exp_q.push_back({fin, (fin == g)});

        seed = s;
        golden = g;
        numPatterns = CW'(n);
        start = 1'b1;
        tick();
        start = 1'b0;
        model_sig = s;
        check("seed_load", 32'(dataOut), 32'(s));
        if (n == 0) begin
            check("empty_busy", 32'(busy), 32'd0);
            check("empty_done", 32'(done), 32'd1);
            return;
        end
        check("busy_rise", 32'(busy), 32'd1);

        for (int i = 0; i < n; i++) begin
            if (i == abort_idx) begin
                abort = 1'b1;
                start = 1'b1;
                dataValid = 1'b1;
                dataIn = resp_q[i];
                tick();
                abort = 1'b0;
                start = 1'b0;
                dataValid = 1'b0;
                check("abort_busy", 32'(busy), 32'd0);
                check("abort_done", 32'(done), 32'd0);
                check("abort_pass", 32'(pass), 32'd0);
                check("abort_hold", 32'(dataOut), 32'(model_sig));
                check("abort_state", 32'(dbg_state), 32'(ST_IDLE));
                return;
            end
            dataValid = 1'b1;
            dataIn = resp_q[i];
            tick();
            dataValid = 1'b0;
            model_sig = ref_step(model_sig, resp_q[i]);
            check("step_sig", 32'(dataOut), 32'(model_sig));
            if (i < n - 1) begin
                check("mid_busy", 32'(busy), 32'd1);
                check("mid_done", 32'(done), 32'd0);
                for (int k = 0; k < gap_q[i]; k++) begin
                    // start during COMPACT must be ignored
                    dataIn = 2'($urandom_range(0, 3));
                    start = 1'($urandom_range(0, 1));
                    seed = 4'($urandom_range(0, 15));
                    tick();
                    start = 1'b0;
                    check("gap_hold", 32'(dataOut), 32'(model_sig));
                    check("gap_busy", 32'(busy), 32'd1);
                end
            end
        end
        check("end_busy", 32'(busy), 32'd0);
        check("end_done", 32'(done), 32'd1);
    endtask

    task automatic set_basic();
        resp_q = '{2'b01, 2'b00, 2'b11};
        gap_q = '{0, 0, 0};
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        int n;
        int ab;
        reset = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        seed = '0;
        numPatterns = '0;
        dataIn = '0;
        dataValid = 1'b0;
        golden = '0;
        #12;
        check("rst_dataOut", 32'(dataOut), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        reset = 1'b1;
        tick();
        // dataValid in IDLE is ignored
        dataValid = 1'b1;
        dataIn = 2'b11;
        tick();
        dataValid = 1'b0;
        check("idle_hold", 32'(dataOut), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);

        // Basic session, matching and non-matching golden.
        set_basic();
        run_session(4'h0, 4'h7, -1);
        tick();
        check("basic_sig", 32'(dataOut), 32'h7);
        check("basic_pass", 32'(pass), 32'd1);
        // DONE holds while dataValid toggles
        dataValid = 1'b1;
        dataIn = 2'b10;
        tick();
        dataValid = 1'b0;
        check("done_hold_sig", 32'(dataOut), 32'h7);
        check("done_hold_done", 32'(done), 32'd1);
        check("done_hold_pass", 32'(pass), 32'd1);

        set_basic();
        run_session(4'h0, 4'h6, -1);
        tick();
        check("basic_fail_pass", 32'(pass), 32'd0);

        // MSB feedback into stages 0 and 1.
        resp_q = '{2'b00};
        gap_q = '{0};
        run_session(4'b1000, 4'b0011, -1);
        check("feedback_sig", 32'(dataOut), 32'h3);

        // Two idle cycles after the first response.
        set_basic();
        gap_q = '{2, 0, 0};
        run_session(4'h0, 4'h7, -1);
        check("gap_final", 32'(dataOut), 32'h7);

        // Empty session.
        resp_q.delete();
        gap_q.delete();
        run_session(4'hA, 4'hA, -1);
        check("empty_sig", 32'(dataOut), 32'hA);
        tick();
        check("empty_pass", 32'(pass), 32'd1);

        // Asynchronous reset after the second response.
        abort = 1'b1;
        tick();
        abort = 1'b0;
        seed = 4'h0;
        numPatterns = 8'd3;
        golden = 4'h7;
        start = 1'b1;
        tick();
        start = 1'b0;
        dataValid = 1'b1;
        dataIn = 2'b01;
        tick();
        dataIn = 2'b00;
        tick();
        dataValid = 1'b0;
        check("pre_reset_sig", 32'(dataOut), 32'h2);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_sig", 32'(dataOut), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_done", 32'(done), 32'd0);
        check("async_rst_pass", 32'(pass), 32'd0);
        #3;
        reset = 1'b1;
        tick();
        check("post_rst_idle", 32'(busy), 32'd0);
        set_basic();
        run_session(4'h0, 4'h7, -1);
        check("post_rst_sig", 32'(dataOut), 32'h7);

        // Abort together with start while compacting, then a clean session.
        set_basic();
        run_session(4'h5, 4'h0, 1);
        set_basic();
        run_session(4'h0, 4'h7, -1);
        check("post_abort_sig", 32'(dataOut), 32'h7);

        // Randomized sessions.
        for (int s = 0; s < 40; s++) begin
            n = $urandom_range(0, 12);
            resp_q.delete();
            gap_q.delete();
            for (int i = 0; i < n; i++) begin
                resp_q.push_back(2'($urandom_range(0, 3)));
                gap_q.push_back($urandom_range(0, 2));
            end
            ab = (n > 0 && $urandom_range(0, 5) == 0) ? $urandom_range(0, n - 1) : -1;
            model_sig = 4'($urandom_range(0, 15));
            seed = model_sig;
            begin
                logic [W-1:0] fin;
                fin = model_sig;
                foreach (resp_q[i]) fin = ref_step(fin, resp_q[i]);
                if ($urandom_range(0, 1) == 1) fin = 4'($urandom_range(0, 15));
                run_session(seed, fin, ab);
            end
            repeat ($urandom_range(0, 2)) tick();
        end

        repeat (3) tick();
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
